// File: rtl/mult_sweep_checker_if.sv
// Operand/product bus between the sweep checker and the multiplier under test.
// The checker drives the operands (master); the multiplier returns the product (slave).
interface mult_sweep_checker_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   x_o;
  logic [WIDTH-1:0]   y_o;
  logic [2*WIDTH-1:0] prod_i;

  modport master (output x_o, output y_o, input prod_i);
  modport slave  (input x_o, input y_o, output prod_i);
endinterface

// File: rtl/mult_sweep_checker.sv
// Exhaustive-sweep harness: walks every (x, y) operand pair through a multiplier,
// compares each settled product against a behavioural golden product and reports the result.
module mult_sweep_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  mult_sweep_checker_if.master mul,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 first_err_valid,
  output logic [WIDTH-1:0]     first_err_x,
  output logic [WIDTH-1:0]     first_err_y,
  output logic [2*WIDTH-1:0]   first_err_prod
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [WIDTH-1:0] OP_MAX      = '1;
  localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   settle_cnt;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;

  logic [PW-1:0]   golden;
  logic            mismatch;
  logic            last_vec;
  logic            begin_sweep;
  logic [PW:0]     err_next;
  logic            busy_d;
  logic            done_d;
  logic            pass_d;

  assign mul.x_o = x_q;
  assign mul.y_o = y_q;

  // Golden is widened before multiplying so the full 2*WIDTH-bit product is kept.
  assign golden      = PW'(x_q) * PW'(y_q);
  assign mismatch    = (state == S_CHECK) && (mul.prod_i != golden);
  assign last_vec    = (x_q == OP_MAX) && (y_q == OP_MAX);
  assign begin_sweep = ((state == S_IDLE) || (state == S_DONE)) && start;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_WAIT;
      S_WAIT:  if (settle_cnt == SETTLE_LAST) next_state = S_CHECK;
      S_CHECK: next_state = last_vec ? S_DONE : S_WAIT;
      S_DONE:  if (start) next_state = S_WAIT;
      default: next_state = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    busy_d   = (next_state == S_WAIT) || (next_state == S_CHECK);
    done_d   = (next_state == S_DONE);
    err_next = begin_sweep ? '0 : err_count + {{PW{1'b0}}, mismatch};
    pass_d   = done_d && (err_next == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_x     <= '0;
      first_err_y     <= '0;
      first_err_prod  <= '0;
      settle_cnt      <= '0;
      x_q             <= '0;
      y_q             <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_next;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            settle_cnt      <= '0;
            x_q             <= '0;
            y_q             <= '0;
            first_err_valid <= 1'b0;
            first_err_x     <= '0;
            first_err_y     <= '0;
            first_err_prod  <= '0;
          end
        end
        S_WAIT: settle_cnt <= settle_cnt + 1'b1;
        S_CHECK: begin
          settle_cnt <= '0;
          if (mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_x     <= x_q;
            first_err_y     <= y_q;
            first_err_prod  <= mul.prod_i;
          end
          // Operands hold at the last vector so the final pair stays visible in DONE.
          if (!last_vec) begin
            y_q <= y_q + 1'b1;
            if (y_q == OP_MAX) x_q <= x_q + 1'b1;
          end
        end
        default: settle_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sweep_checker.sv
// Scoreboard bench: two checkers (SETTLE=1 and SETTLE=3) sweep a bench multiplier
// that can be correct, carry a stuck-at fault, or return its product two cycles late.
module tb_mult_sweep_checker;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1;
  logic       start3;
  logic [1:0] mode;   // 0 correct, 1 bit7 stuck-0, 2 bit0 stuck-1, 3 two-cycle delayed

  int checks   = 0;
  int failures = 0;

  mult_sweep_checker_if #(.WIDTH(W)) m1 ();
  mult_sweep_checker_if #(.WIDTH(W)) m3 ();

  logic          busy1, done1, pass1, fev1;
  logic [PW:0]   err1;
  logic [W-1:0]  fx1, fy1;
  logic [PW-1:0] fp1;
  logic          busy3, done3, pass3, fev3;
  logic [PW:0]   err3;
  logic [W-1:0]  fx3, fy3;
  logic [PW-1:0] fp3;

  mult_sweep_checker #(.WIDTH(W), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mul(m1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fev1), .first_err_x(fx1), .first_err_y(fy1), .first_err_prod(fp1)
  );

  mult_sweep_checker #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mul(m3.master),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_valid(fev3), .first_err_x(fx3), .first_err_y(fy3), .first_err_prod(fp3)
  );

  function automatic logic [PW-1:0] model(input logic [1:0] m, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [PW-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    if (m == 2'd1) p[7] = 1'b0;
    if (m == 2'd2) p[0] = 1'b1;
    return p;
  endfunction

  logic [PW-1:0] p1a = '0, p1b = '0, p3a = '0, p3b = '0;
  always @(posedge clk) begin
    p1a <= model(2'd0, m1.x_o, m1.y_o);
    p1b <= p1a;
    p3a <= model(2'd0, m3.x_o, m3.y_o);
    p3b <= p3a;
  end

  always_comb m1.prod_i = (mode == 2'd3) ? p1b : model(mode, m1.x_o, m1.y_o);
  always_comb m3.prod_i = (mode == 2'd3) ? p3b : model(mode, m3.x_o, m3.y_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic          pass;
    logic [PW:0]   err;
    logic          err_nonzero_only;
    logic          chk_first;
    logic          fev;
    logic [W-1:0]  fx;
    logic [W-1:0]  fy;
    logic [PW-1:0] fp;
    int            busy_edges;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  task automatic compare(input string tag, input exp_t e, input logic p, input logic [PW:0] er,
                         input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [PW-1:0] fp, input int run, input logic ov);
    check({tag, "_pass"}, 32'(p), 32'(e.pass));
    if (e.err_nonzero_only) check({tag, "_err_nonzero"}, 32'(er != '0), 32'd1);
    else                    check({tag, "_err_count"}, 32'(er), 32'(e.err));
    if (e.chk_first) begin
      check({tag, "_first_valid"}, 32'(v), 32'(e.fev));
      check({tag, "_first_x"}, 32'(x), 32'(e.fx));
      check({tag, "_first_y"}, 32'(y), 32'(e.fy));
      check({tag, "_first_prod"}, 32'(fp), 32'(e.fp));
    end
    check({tag, "_busy_edges"}, 32'(run), 32'(e.busy_edges));
    check({tag, "_busy_done_overlap"}, 32'(ov), 32'd0);
  endtask

  // Monitors: count busy cycles per sweep and score each rising done.
  int   run1 = 0, run3 = 0;
  logic ov1 = 1'b0, ov3 = 1'b0, dp1 = 1'b0, dp3 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      run1 = 0;
      ov1  = 1'b0;
    end else begin
      if (busy1) run1++;
      if (busy1 && done1) ov1 = 1'b1;
      if (done1 && !dp1) begin
        if (q1.size() == 0) check("dut1_unexpected_done", 32'd1, 32'd0);
        else compare("dut1", q1.pop_front(), pass1, err1, fev1, fx1, fy1, fp1, run1, ov1);
        run1 = 0;
        ov1  = 1'b0;
      end
    end
    dp1 = done1;
  end

  always @(negedge clk) begin
    if (rst) begin
      run3 = 0;
      ov3  = 1'b0;
    end else begin
      if (busy3) run3++;
      if (busy3 && done3) ov3 = 1'b1;
      if (done3 && !dp3) begin
        if (q3.size() == 0) check("dut3_unexpected_done", 32'd1, 32'd0);
        else compare("dut3", q3.pop_front(), pass3, err3, fev3, fx3, fy3, fp3, run3, ov3);
        run3 = 0;
        ov3  = 1'b0;
      end
    end
    dp3 = done3;
  end

  task automatic pulse_start1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  task automatic wait_done1(input int budget, input string tag);
    int n = 0;
    while (!done1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_reached"}, 32'(done1), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done3(input int budget, input string tag);
    int n = 0;
    while (!done3 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_reached"}, 32'(done3), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset1(input string tag);
    check({tag, "_busy"}, 32'(busy1), 32'd0);
    check({tag, "_done"}, 32'(done1), 32'd0);
    check({tag, "_pass"}, 32'(pass1), 32'd0);
    check({tag, "_err"}, 32'(err1), 32'd0);
    check({tag, "_fev"}, 32'(fev1), 32'd0);
    check({tag, "_fx"}, 32'(fx1), 32'd0);
    check({tag, "_fy"}, 32'(fy1), 32'd0);
    check({tag, "_fp"}, 32'(fp1), 32'd0);
    check({tag, "_x"}, 32'(m1.x_o), 32'd0);
    check({tag, "_y"}, 32'(m1.y_o), 32'd0);
  endtask

  function automatic exp_t mk(input logic p, input logic [PW:0] er, input logic nz,
                              input logic cf, input logic v, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [PW-1:0] fp, input int be);
    exp_t e;
    e.pass = p; e.err = er; e.err_nonzero_only = nz; e.chk_first = cf;
    e.fev = v; e.fx = x; e.fy = y; e.fp = fp; e.busy_edges = be;
    return e;
  endfunction

  initial begin
    int n;
    rst    = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    mode   = 2'd0;
    repeat (3) @(negedge clk);
    check_reset1("reset");
    check("reset_dut3_busy", 32'(busy3), 32'd0);
    check("reset_dut3_done", 32'(done3), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Correct multiplier, with extra start pulses while busy that must be ignored.
    q1.push_back(mk(1'b1, '0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 512));
    pulse_start1();
    check("started_busy", 32'(busy1), 32'd1);
    for (int i = 0; i < 3; i++) begin
      repeat (37) @(negedge clk);
      pulse_start1();
    end
    wait_done1(1200, "good");

    // Bit 7 stuck at 0: every product >= 128 fails, first at 9*15 = 0x87 -> 0x07.
    mode = 2'd1;
    q1.push_back(mk(1'b0, 9'd32, 1'b0, 1'b1, 1'b1, 4'd9, 4'd15, 8'h07, 512));
    pulse_start1();
    wait_done1(1200, "b7sa0");

    // Restart from DONE: results clear on the start edge; bit 0 stuck at 1 fails all even products.
    mode = 2'd2;
    q1.push_back(mk(1'b0, 9'd192, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 8'h01, 512));
    pulse_start1();
    check("restart_err_cleared", 32'(err1), 32'd0);
    check("restart_fev_cleared", 32'(fev1), 32'd0);
    check("restart_x0", 32'(m1.x_o), 32'd0);
    check("restart_y0", 32'(m1.y_o), 32'd0);
    check("restart_done_low", 32'(done1), 32'd0);
    wait_done1(1200, "b0sa1");

    // Reset mid-sweep at (5,3); then rst and start together must stay in IDLE.
    mode = 2'd0;
    pulse_start1();
    n = 0;
    while (!(m1.x_o == 4'd5 && m1.y_o == 4'd3) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reached_5_3", 32'(m1.x_o == 4'd5 && m1.y_o == 4'd3), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset1("midreset");
    start1 = 1'b1;
    @(negedge clk);
    check("rst_start_busy", 32'(busy1), 32'd0);
    check("rst_start_done", 32'(done1), 32'd0);
    rst    = 1'b0;
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("after_rst_start_idle", 32'(busy1), 32'd0);

    // Two-cycle-late product: SETTLE=3 absorbs it, SETTLE=1 does not.
    mode = 2'd3;
    q1.push_back(mk(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 512));
    q3.push_back(mk(1'b1, '0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 1024));
    @(negedge clk);
    start1 = 1'b1;
    start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    wait_done1(1200, "late_s1");
    wait_done3(1200, "late_s3");

    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
